// File: rtl/pipeline_sequencer_if.sv
// Bundle between the debug unit / hazard logic and the pipeline sequencer.
//   Command handshake : i_cmd_valid, i_cmd (00 NOP, 01 RUN, 10 STEP, 11 STOP), o_cmd_ready
//   Pipeline events   : i_halt_id, i_halt_wb, i_load_use, i_branch_taken
//   Register controls : o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_enable,
//                       o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable
// Signal names keep the sequencer's point of view (i_ = into the sequencer).
// The slave modport is taken by the sequencer, the master modport by whoever drives it.
interface pipeline_sequencer_if;
  logic       i_cmd_valid;
  logic [1:0] i_cmd;
  logic       o_cmd_ready;

  logic       i_halt_id;
  logic       i_halt_wb;
  logic       i_load_use;
  logic       i_branch_taken;

  logic       o_pc_enable;
  logic       o_if_id_enable;
  logic       o_if_id_flush;
  logic       o_id_ex_enable;
  logic       o_id_ex_flush;
  logic       o_ex_mem_enable;
  logic       o_mem_wb_enable;

  modport master (
    output i_cmd_valid, i_cmd, i_halt_id, i_halt_wb, i_load_use, i_branch_taken,
    input  o_cmd_ready, o_pc_enable, o_if_id_enable, o_if_id_flush,
           o_id_ex_enable, o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_id, i_halt_wb, i_load_use, i_branch_taken,
    output o_cmd_ready, o_pc_enable, o_if_id_enable, o_if_id_flush,
           o_id_ex_enable, o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the 5-stage MIPS pipeline. Turns debug commands and
// hazard/halt events into enable/flush controls for the PC and the four pipeline
// registers, including load-use bubbles, branch flushes and the post-halt drain.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   bus (slave)     : command handshake, hazard/halt events, register enables/flushes
//   o_state         : current state (IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4)
//   o_halted        : high while in HALTED
//   o_cycle_count   : saturating count of cycles in which the pipeline advanced
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_SIZE     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  pipeline_sequencer_if.slave bus,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [CNT_SIZE-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_STOP = 2'b11
  } cmd_t;

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
  // Value held by the drain counter during the final watchdog cycle.
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_SIZE-1:0] cycle_count_q, cycle_count_d;

  logic cmd_ready, cmd_fire, advanced;
  logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;
    advanced      = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_fl      = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_fl      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;

    cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    cmd_fire  = bus.i_cmd_valid && cmd_ready;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire && bus.i_cmd == CMD_RUN)       state_d = S_RUN;
        else if (cmd_fire && bus.i_cmd == CMD_STEP) state_d = S_STEP;
      end

      S_RUN, S_STEP: begin
        advanced  = 1'b1;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if (bus.i_load_use) begin
          // Hold PC and IF/ID, bubble ID/EX; the pending branch is seen again next cycle.
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_fl = 1'b1;
        end else if (bus.i_branch_taken) begin
          if_id_fl = 1'b1;
        end

        if (state_q == S_STEP)                            state_d = S_IDLE;
        else if (cmd_fire && bus.i_cmd == CMD_STOP)       state_d = S_IDLE;
        // A decoded HALT (not stalled) wins over STOP and the STEP return.
        if (bus.i_halt_id && !bus.i_load_use) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end

      S_DRAIN: begin
        // Freeze fetch, feed bubbles into ID/EX and let the tail retire.
        advanced    = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_fl    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        if (bus.i_halt_wb || drain_cnt_q == DRAIN_LAST) state_d = S_HALTED;
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_IDLE;
    endcase

    if (advanced && !(&cycle_count_q)) cycle_count_d = cycle_count_q + CNT_SIZE'(1);

    // Reset must silence the pipeline in the same cycle, before the state clears.
    if (i_reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      if_id_fl  = 1'b0;
      id_ex_en  = 1'b0;
      id_ex_fl  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.o_cmd_ready     = cmd_ready;
  assign bus.o_pc_enable     = pc_en;
  assign bus.o_if_id_enable  = if_id_en;
  assign bus.o_if_id_flush   = if_id_fl;
  assign bus.o_id_ex_enable  = id_ex_en;
  assign bus.o_id_ex_flush   = id_ex_fl;
  assign bus.o_ex_mem_enable = ex_mem_en;
  assign bus.o_mem_wb_enable = mem_wb_en;

  assign o_state       = state_q;
  assign o_halted      = (state_q == S_HALTED);
  assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed command/hazard sequences, a
// rule-level reference model compared on every falling edge, and literal spot checks.
module tb_pipeline_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  o_state;
  logic        o_halted;
  logic [31:0] o_cycle_count;

  pipeline_sequencer_if bus ();

  pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_SIZE(32)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .bus          (bus),
    .o_state      (o_state),
    .o_halted     (o_halted),
    .o_cycle_count(o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Control word order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] W_OFF    = 7'b000_0000;
  localparam logic [6:0] W_ADV    = 7'b110_1011;
  localparam logic [6:0] W_BRANCH = 7'b111_1011;
  localparam logic [6:0] W_BUBBLE = 7'b000_1111;  // load-use stall and drain look alike

  logic [6:0] dut_ctrl;
  assign dut_ctrl = {bus.o_pc_enable, bus.o_if_id_enable, bus.o_if_id_flush,
                     bus.o_id_ex_enable, bus.o_id_ex_flush, bus.o_ex_mem_enable,
                     bus.o_mem_wb_enable};

  // ---------------- reference model (per-cycle rules, plain integers) ----------------
  int     m_state = 0;
  longint m_cnt   = 0;
  int     m_drain = 0;
  bit     m_valid = 1'b0;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  always @(negedge clk) begin
    int     ns, nd;
    longint nc;
    logic [6:0] exp_ctrl;
    bit ready, fire, adv;
    ready = (m_state == 0) || (m_state == 1);
    adv   = (m_state == 1) || (m_state == 2);
    fire  = bus.i_cmd_valid && ready;

    if (m_valid) begin
      if (rst || m_state == 0 || m_state == 4) exp_ctrl = W_OFF;
      else if (m_state == 3)                   exp_ctrl = W_BUBBLE;
      else if (bus.i_load_use)                 exp_ctrl = W_BUBBLE;
      else if (bus.i_branch_taken)             exp_ctrl = W_BRANCH;
      else                                     exp_ctrl = W_ADV;
      check("state", 64'(o_state), 64'(m_state));
      check("ctrl", 64'(dut_ctrl), 64'(exp_ctrl));
      check("cmd_ready", 64'(bus.o_cmd_ready), 64'(ready));
      check("halted", 64'(o_halted), 64'(m_state == 4));
      check("cycle_count", 64'(o_cycle_count), 64'(m_cnt));
    end

    ns = m_state; nc = m_cnt; nd = m_drain;
    if (adv || m_state == 3) nc = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
    case (m_state)
      0: begin
        if (fire && bus.i_cmd == 2'b01)      ns = 1;
        else if (fire && bus.i_cmd == 2'b10) ns = 2;
      end
      1, 2: begin
        if (m_state == 2 || (fire && bus.i_cmd == 2'b11)) ns = 0;
        if (bus.i_halt_id && !bus.i_load_use) begin ns = 3; nd = 0; end
      end
      3: begin
        nd = m_drain + 1;
        if (bus.i_halt_wb || nd >= 4) ns = 4;
      end
      default: ;
    endcase

    if (rst) begin
      m_state <= 0; m_cnt <= 0; m_drain <= 0; m_valid <= 1'b1;
    end else if (m_valid) begin
      m_state <= ns; m_cnt <= nc; m_drain <= nd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [1:0] c, input bit hid, input bit hwb,
                       input bit lu, input bit bt);
    bus.i_cmd_valid    = v;
    bus.i_cmd          = c;
    bus.i_halt_id      = hid;
    bus.i_halt_wb      = hwb;
    bus.i_load_use     = lu;
    bus.i_branch_taken = bt;
  endtask

  task automatic idle_in();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    do_reset();

    // 1. reset state, RUN for 10 advance cycles, STOP
    #1;
    check("lit_reset_state", 64'(o_state), 64'd0);
    check("lit_reset_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("lit_reset_count", 64'(o_cycle_count), 64'd0);
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);   // STOP in IDLE is ignored
    tick();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in(); #1;
    check("lit_run_state", 64'(o_state), 64'd1);
    check("lit_run_ctrl", 64'(dut_ctrl), 64'(W_ADV));
    repeat (9) tick();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in(); #1;
    check("lit_stop_state", 64'(o_state), 64'd0);
    check("lit_stop_ctrl", 64'(dut_ctrl), 64'(W_OFF));
    check("lit_stop_count", 64'(o_cycle_count), 64'd10);

    // 2. STEP, then a STEP offered while not ready is dropped
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    check("lit_step_state", 64'(o_state), 64'd2);
    check("lit_step_ready", 64'(bus.o_cmd_ready), 64'd0);
    tick();
    idle_in();
    tick(); #1;
    check("lit_step_back_idle", 64'(o_state), 64'd0);
    check("lit_step_count", 64'(o_cycle_count), 64'd11);

    // 3/4. hazards in RUN
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    check("lit_loaduse_ctrl", 64'(dut_ctrl), 64'(W_BUBBLE));
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("lit_branch_ctrl", 64'(dut_ctrl), 64'(W_BRANCH));
    tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);   // load-use blocks halt entry
    tick();
    idle_in(); #1;
    check("lit_loaduse_no_drain", 64'(o_state), 64'd1);

    // 5. halt in RUN (with STOP offered too), halt_wb on 3rd drain cycle
    drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in(); #1;
    check("lit_drain_state", 64'(o_state), 64'd3);
    check("lit_drain_ctrl", 64'(dut_ctrl), 64'(W_BUBBLE));
    tick();
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    check("lit_halted_state", 64'(o_state), 64'd4);
    check("lit_halted_flag", 64'(o_halted), 64'd1);
    check("lit_halted_ctrl", 64'(dut_ctrl), 64'(W_OFF));
    check("lit_halted_count", 64'(o_cycle_count), 64'd18);
    tick();
    tick(); #1;
    check("lit_halted_sticky", 64'(o_state), 64'd4);

    // 5b. drain watchdog without halt_wb
    do_reset();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    repeat (3) tick();
    #1;
    check("lit_wd_still_drain", 64'(o_state), 64'd3);
    tick(); #1;
    check("lit_wd_halted", 64'(o_state), 64'd4);
    check("lit_wd_count", 64'(o_cycle_count), 64'd5);

    // 6. reset in the middle of DRAIN
    do_reset();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);   // halt_id with stall: stays RUN
    tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    rst = 1'b1; #1;
    check("lit_rst_drain_state", 64'(o_state), 64'd3);
    check("lit_rst_ctrl_off", 64'(dut_ctrl), 64'(W_OFF));
    tick();
    rst = 1'b0; #1;
    check("lit_rst_idle", 64'(o_state), 64'd0);
    check("lit_rst_count", 64'(o_cycle_count), 64'd0);
    check("lit_rst_ready", 64'(bus.o_cmd_ready), 64'd1);

    // Short STEP into a halt: halt overrides the STEP return.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in(); #1;
    check("lit_step_halt_drain", 64'(o_state), 64'd3);
    repeat (6) tick();

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
